// File: rtl/iter_shifter.sv
// Multi-cycle barrel-free shifter: one bit position per clock, LSL/LSR/ASR/ROR with carry-out.
// Feeds the shift operand of the MOV/ALU result select stage.
module iter_shifter #(
    parameter int unsigned N  = 32,
    parameter int unsigned AW = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [N-1:0]  operand,
    input  logic [AW-1:0] shamt,
    input  logic [1:0]    shtype,
    input  logic          carry_in,
    output logic          ready,
    output logic          busy,
    output logic          done,
    output logic [N-1:0]  result,
    output logic          carry_out
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] ShLsl = 2'b00;
    localparam logic [1:0] ShLsr = 2'b01;
    localparam logic [1:0] ShAsr = 2'b10;
    localparam logic [1:0] ShRor = 2'b11;

    state_e        state_q, state_d;
    logic [N-1:0]  result_q, result_d;
    logic          carry_q, carry_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [1:0]    type_q, type_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            result_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            type_q   <= ShLsl;
        end else begin
            state_q  <= state_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            type_q   <= type_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        type_d   = type_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    result_d = operand;
                    carry_d  = carry_in;
                    cnt_d    = shamt;
                    type_d   = shtype;
                    state_d  = (shamt == '0) ? StDone : StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                unique case (type_q)
                    ShLsl: begin
                        result_d = {result_q[N-2:0], 1'b0};
                        carry_d  = result_q[N-1];
                    end
                    ShLsr: begin
                        result_d = {1'b0, result_q[N-1:1]};
                        carry_d  = result_q[0];
                    end
                    ShAsr: begin
                        result_d = {result_q[N-1], result_q[N-1:1]};
                        carry_d  = result_q[0];
                    end
                    ShRor: begin
                        result_d = {result_q[0], result_q[N-1:1]};
                        carry_d  = result_q[0];
                    end
                    default: ;
                endcase
                cnt_d = cnt_q - AW'(1);
                // Last step happens on the edge where the count is 1.
                if (cnt_q == AW'(1)) begin
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign ready     = (state_q == StIdle) || (state_q == StDone);
    assign busy      = (state_q == StShift);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: tb/tb_iter_shifter.sv
// Randomized and directed bench for iter_shifter against an arithmetic shift model.
module tb_iter_shifter;

    localparam int N = 32;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [N-1:0]  operand;
    logic [4:0]    shamt;
    logic [1:0]    shtype;
    logic          carry_in;
    logic          ready;
    logic          busy;
    logic          done;
    logic [N-1:0]  result;
    logic          carry_out;

    int passes = 0;
    int total  = 0;

    iter_shifter #(.N(N), .AW(5)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .operand   (operand),
        .shamt     (shamt),
        .shtype    (shtype),
        .carry_in  (carry_in),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .result    (result),
        .carry_out (carry_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Reference: whole shift computed at once from the shift rules.
    task automatic model(input logic [31:0] op, input int s, input logic [1:0] t,
                         input logic cin, output logic [31:0] r, output logic c);
        if (s == 0) begin
            r = op;
            c = cin;
        end else begin
            case (t)
                2'b00: begin r = op << s; c = op[32-s]; end
                2'b01: begin r = op >> s; c = op[s-1]; end
                2'b10: begin r = 32'($signed(op) >>> s); c = op[s-1]; end
                default: begin r = (op >> s) | (op << (32 - s)); c = op[s-1]; end
            endcase
        end
    endtask

    // Called at a negedge; start is accepted at the following posedge.
    task automatic issue(input logic [31:0] op, input int s, input logic [1:0] t,
                         input logic cin, input bit hold);
        chk("ready_before_start", ready, 1);
        start    = 1'b1;
        operand  = op;
        shamt    = 5'(s);
        shtype   = t;
        carry_in = cin;
        @(negedge clk);
        if (!hold) start = 1'b0;
    endtask

    // Entered at the first negedge after acceptance; returns at the negedge where done is seen.
    task automatic wait_done(input string tag, input int lat, input logic [31:0] er,
                             input logic ec, input bit scramble);
        int k = 1;
        while (done !== 1'b1 && k < 40) begin
            chk({tag, "_busy"}, busy, 1);
            if (scramble) begin
                operand  = $urandom;
                shamt    = 5'($urandom_range(0, 31));
                shtype   = 2'($urandom_range(0, 3));
                carry_in = 1'($urandom_range(0, 1));
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        chk({tag, "_done"}, done, 1);
        chk({tag, "_latency"}, k, lat);
        chk({tag, "_result"}, result, er);
        chk({tag, "_carry"}, carry_out, ec);
        chk({tag, "_ready_in_done"}, ready, 1);
    endtask

    task automatic after_done(input string tag, input logic [31:0] er, input logic ec);
        @(negedge clk);
        chk({tag, "_done_single"}, done, 0);
        chk({tag, "_hold_result"}, result, er);
        chk({tag, "_hold_carry"}, carry_out, ec);
    endtask

    initial begin
        logic [31:0] er;
        logic        ec;
        int          s;
        logic [1:0]  t;
        logic [31:0] op;
        logic        cin;
        bit          seen;

        rst_n = 1'b0; start = 1'b0; operand = '0; shamt = '0; shtype = '0; carry_in = 1'b0;
        #12;
        chk("rst_result", result, 0);
        chk("rst_carry", carry_out, 0);
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-operation
        issue(32'hFFFF_FFFF, 20, 2'b00, 1'b0, 1'b0);
        repeat (4) @(negedge clk);
        chk("midrst_busy_before", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("midrst_result", result, 0);
        chk("midrst_carry", carry_out, 0);
        chk("midrst_ready", ready, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (30) begin
            @(negedge clk);
            if (done === 1'b1) seen = 1'b1;
        end
        chk("midrst_no_done", seen, 0);

        // LSL 0xF1 by 4
        issue(32'h0000_00F1, 4, 2'b00, 1'b0, 1'b0);
        wait_done("lsl4", 5, 32'h0000_0F10, 1'b0, 1'b0);
        after_done("lsl4", 32'h0000_0F10, 1'b0);

        issue(32'h8000_0001, 1, 2'b01, 1'b0, 1'b0);
        wait_done("lsr1", 2, 32'h4000_0000, 1'b1, 1'b0);
        after_done("lsr1", 32'h4000_0000, 1'b1);

        issue(32'h0000_0001, 1, 2'b11, 1'b0, 1'b0);
        wait_done("ror1", 2, 32'h8000_0000, 1'b1, 1'b0);
        after_done("ror1", 32'h8000_0000, 1'b1);

        issue(32'h8000_0000, 31, 2'b10, 1'b1, 1'b0);
        wait_done("asr31", 32, 32'hFFFF_FFFF, 1'b0, 1'b0);
        after_done("asr31", 32'hFFFF_FFFF, 1'b0);

        for (int i = 0; i < 4; i++) begin
            issue(32'h1234_5678, 0, 2'(i), 1'b1, 1'b0);
            wait_done("zero", 1, 32'h1234_5678, 1'b1, 1'b0);
            after_done("zero", 32'h1234_5678, 1'b1);
        end

        // start held with changing operands while shifting
        issue(32'h0000_00F0, 6, 2'b01, 1'b0, 1'b1);
        wait_done("held_start", 7, 32'h0000_0003, 1'b1, 1'b1);
        after_done("held_start", 32'h0000_0003, 1'b1);

        // Back-to-back: new start during the DONE cycle
        issue(32'h0000_0010, 3, 2'b01, 1'b0, 1'b0);
        wait_done("b2b_first", 4, 32'h0000_0002, 1'b0, 1'b0);
        start = 1'b1; operand = 32'h1; shamt = 5'd2; shtype = 2'b00; carry_in = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("b2b_no_repeat_done", done, 0);
        wait_done("b2b_second", 3, 32'h0000_0004, 1'b0, 1'b0);
        after_done("b2b_second", 32'h0000_0004, 1'b0);

        for (int i = 0; i < 40; i++) begin
            op  = $urandom;
            s   = $urandom_range(0, 31);
            t   = 2'($urandom_range(0, 3));
            cin = 1'($urandom_range(0, 1));
            model(op, s, t, cin, er, ec);
            issue(op, s, t, cin, 1'b0);
            wait_done("rand", s + 1, er, ec, 1'b0);
            if (i % 2 == 0) after_done("rand", er, ec);
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
